// File: rtl/uart_tx.sv
// UART transmitter with a small input FIFO: start bit (0), N_BITS data bits LSB first,
// one stop bit (1), no parity. Frames leave back to back while the FIFO holds words.
module uart_tx #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int N_BITS     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_BITS-1:0]           uart_tx_tdata,
    input  logic                        uart_tx_tvalid,
    output logic                        uart_tx_tready,
    output logic                        tx_data,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_BITS - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [N_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    state_t            state_r;
    logic [CW-1:0]     baud_cnt_r;
    logic [BW-1:0]     bit_idx_r;
    logic [N_BITS-1:0] shift_r;
    logic              tx_data_r;

    logic              full_s;
    logic              wr_en_s;
    logic              baud_end_s;
    logic              pop_s;
    logic [N_BITS-1:0] head_s;

    assign full_s         = (count_r == CNT_FULL);
    assign uart_tx_tready = !full_s && !rst;
    assign wr_en_s        = uart_tx_tvalid && !full_s && !rst;
    assign baud_end_s     = (baud_cnt_r == BAUD_LAST);
    assign head_s         = mem_r[rd_ptr_r];
    assign tx_data        = tx_data_r;
    assign fifo_count     = count_r;
    assign tx_busy        = (state_r != IDLE) || (count_r != {(AW+1){1'b0}});

    // Pop the head word when a new frame may begin: from IDLE, or at the last STOP cycle.
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE:    pop_s = (count_r != {(AW+1){1'b0}});
            STOP:    pop_s = baud_end_s && (count_r != {(AW+1){1'b0}});
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= uart_tx_tdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame sequencer: every bit is held for CLKS_PER_BIT cycles of the baud counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tx_data_r  <= 1'b1;
            baud_cnt_r <= {CW{1'b0}};
            bit_idx_r  <= {BW{1'b0}};
            shift_r    <= {N_BITS{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= {CW{1'b0}};
                    bit_idx_r  <= {BW{1'b0}};
                    if (pop_s) begin
                        shift_r   <= head_s;
                        tx_data_r <= 1'b0;
                        state_r   <= START;
                    end else begin
                        tx_data_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= {CW{1'b0}};
                        bit_idx_r  <= {BW{1'b0}};
                        tx_data_r  <= shift_r[0];
                        shift_r    <= shift_r >> 1'b1;
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1'b1);
                    end
                end
                DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= {CW{1'b0}};
                        if (bit_idx_r == BIT_LAST) begin
                            tx_data_r <= 1'b1;
                            state_r   <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + BW'(1'b1);
                            tx_data_r <= shift_r[0];
                            shift_r   <= shift_r >> 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1'b1);
                    end
                end
                STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= {CW{1'b0}};
                        if (pop_s) begin
                            // Next word queued: skip IDLE so frames stay contiguous.
                            shift_r   <= head_s;
                            tx_data_r <= 1'b0;
                            state_r   <= START;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tx_data_r  <= 1'b1;
                    baud_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default instance for directed timing scenarios, plus a
// 4-clocks-per-bit, 7-bit instance for the parameter case and randomized traffic.
module tb_uart_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, tvalid_a, tready_a, tx_a, busy_a;
    logic [7:0] tdata_a;
    logic [2:0] count_a;
    logic       rst_b, tvalid_b, tready_b, tx_b, busy_b;
    logic [6:0] tdata_b;
    logic [2:0] count_b;

    uart_tx u_dut_a (
        .clk(clk), .rst(rst_a), .uart_tx_tdata(tdata_a), .uart_tx_tvalid(tvalid_a),
        .uart_tx_tready(tready_a), .tx_data(tx_a), .tx_busy(busy_a), .fifo_count(count_a)
    );

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .N_BITS(7), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .uart_tx_tdata(tdata_b), .uart_tx_tvalid(tvalid_b),
        .uart_tx_tready(tready_b), .tx_data(tx_b), .tx_busy(busy_b), .fifo_count(count_b)
    );

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic [6:0] model_q[$];
    bit drv_done = 1'b0;
    int accepted = 0;
    int decoded = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line bits in time order from bit 0: start, data LSB first, stop
    } vec_t;
    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic tx_line(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic [9:0] frame_of(input logic [7:0] w);
        return {1'b1, w, 1'b0};
    endfunction

    task automatic load_frame(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
    endtask

    // Walks every cycle of the queued bits; one comparison per bit period.
    task automatic check_line(input bit sel, input int cpb, input int skip, input string tag);
        int nb;
        nb = exp_q.size();
        for (int b = 0; b < nb; b++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < cpb; c++) begin
                if (b * cpb + c >= skip) begin
                    if (tx_line(sel) !== exp_q[b]) bad++;
                    step();
                end
            end
            check($sformatf("%s bit %0d wrong-cycle count", tag, b), bad, 0);
        end
        exp_q.delete();
    endtask

    initial begin
        int idx;
        int guard;
        logic acc;
        int lows;

        vecs[0] = '{8'h00, 10'h200};
        vecs[1] = '{8'hFF, 10'h3FE};
        vecs[2] = '{8'hA5, 10'h34A};
        vecs[3] = '{8'h3C, 10'h278};
        vecs[4] = '{8'h81, 10'h302};

        rst_a = 1'b1; rst_b = 1'b1;
        tvalid_a = 1'b0; tvalid_b = 1'b0;
        tdata_a = 8'h00; tdata_b = 7'h00;
        repeat (3) step();
        check("reset tx", tx_a, 1'b1);
        check("reset busy", busy_a, 1'b0);
        check("reset count", count_a, 3'd0);
        check("reset tready low", tready_a, 1'b0);
        check("reset tx b", tx_b, 1'b1);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("tready after reset", tready_a, 1'b1);
        check("tready after reset b", tready_b, 1'b1);

        // Single word, 1-cycle latency from idle
        tdata_a = 8'h55; tvalid_a = 1'b1;
        step();
        tvalid_a = 1'b0;
        check("single count at accept", count_a, 3'd1);
        check("single tx at accept", tx_a, 1'b1);
        step();
        check("single busy", busy_a, 1'b1);
        check("single count after pop", count_a, 3'd0);
        load_frame(10'h2AA, 10);
        check_line(1'b0, 217, 0, "single");
        check("single busy after stop", busy_a, 1'b0);
        check("single idle line", tx_a, 1'b1);

        // Back-to-back from the vector table with tvalid held
        idx = 0; guard = 0;
        while (idx < 5 && guard < 20) begin
            tdata_a = vecs[idx].data;
            tvalid_a = 1'b1;
            acc = tready_a;
            step();
            if (acc) idx++;
            guard++;
        end
        check("b2b accepted", idx, 5);
        check("b2b count full", count_a, 3'd4);
        check("b2b tready low", tready_a, 1'b0);
        tdata_a = 8'hEE;
        step();
        tvalid_a = 1'b0;
        check("b2b no write when full", count_a, 3'd4);
        for (int i = 0; i < 5; i++) load_frame(vecs[i].frame, 10);
        check_line(1'b0, 217, 4, "b2b");
        check("b2b busy end", busy_a, 1'b0);

        // Push on the STOP-end popping edge keeps count and order
        check("pp tready", tready_a, 1'b1);
        tdata_a = 8'h3A; tvalid_a = 1'b1;
        step();
        tdata_a = 8'hC5;
        step();
        tvalid_a = 1'b0;
        check("pp count idle push/pop", count_a, 3'd1);
        load_frame(frame_of(8'h3A), 9);
        check_line(1'b0, 217, 0, "pp first");
        repeat (216) step();
        check("pp stop high", tx_a, 1'b1);
        check("pp count before edge", count_a, 3'd1);
        tdata_a = 8'h96; tvalid_a = 1'b1;
        step();
        tvalid_a = 1'b0;
        check("pp count across push/pop", count_a, 3'd1);
        load_frame(frame_of(8'hC5), 10);
        load_frame(frame_of(8'h96), 10);
        check_line(1'b0, 217, 0, "pp tail");
        check("pp busy end", busy_a, 1'b0);

        // Reset during DATA bit 3 with two words queued
        tvalid_a = 1'b1;
        tdata_a = 8'h12; step();
        tdata_a = 8'h34; step();
        tdata_a = 8'h56; step();
        tvalid_a = 1'b0;
        check("rst queued", count_a, 3'd2);
        repeat (899) step();
        check("rst pre bit3", tx_a, 1'b0);
        rst_a = 1'b1;
        step();
        check("rst tx high", tx_a, 1'b1);
        check("rst count flushed", count_a, 3'd0);
        check("rst busy", busy_a, 1'b0);
        check("rst tready low", tready_a, 1'b0);
        rst_a = 1'b0;
        #1;
        check("rst tready after", tready_a, 1'b1);
        lows = 0;
        repeat (3000) begin
            step();
            if (tx_a !== 1'b1) lows++;
        end
        check("rst no more frames", lows, 0);
        check("rst busy stays low", busy_a, 1'b0);

        // Parameter instance: 4 clocks/bit, 7 data bits
        tdata_b = 7'h41; tvalid_b = 1'b1;
        step();
        tvalid_b = 1'b0;
        check("param count at accept", count_b, 3'd1);
        step();
        load_frame(10'h182, 9);
        check_line(1'b1, 4, 0, "param");
        check("param busy after 36", busy_b, 1'b0);

        // Randomized traffic against a queue-and-decode reference
        fork
            begin
                for (int c = 0; c < 1500; c++) begin
                    logic a;
                    tvalid_b = (c < 700) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 59) == 0);
                    tdata_b = 7'($urandom);
                    a = tvalid_b && tready_b;
                    step();
                    if (a) begin
                        model_q.push_back(tdata_b);
                        accepted++;
                    end
                end
                tvalid_b = 1'b0;
                drv_done = 1'b1;
            end
            begin
                bit timed_out;
                timed_out = 1'b1;
                for (int c = 0; c < 8000; c++) begin
                    if (drv_done && model_q.size() == 0 && busy_b === 1'b0) begin
                        timed_out = 1'b0;
                        break;
                    end
                    if (tx_b === 1'b0) begin
                        logic [6:0] w;
                        logic st, sp;
                        repeat (2) step();
                        st = tx_b;
                        for (int b = 0; b < 7; b++) begin
                            repeat (4) step();
                            w[b] = tx_b;
                        end
                        repeat (4) step();
                        sp = tx_b;
                        repeat (2) step();
                        check("rand start bit", st, 1'b0);
                        check("rand stop bit", sp, 1'b1);
                        check("rand frame had queued word", model_q.size() > 0, 1'b1);
                        if (model_q.size() > 0) check("rand data", w, model_q.pop_front());
                        decoded++;
                        c += 35;
                    end else begin
                        step();
                    end
                end
                check("rand drain timeout", timed_out, 1'b0);
            end
        join
        check("rand decoded all", decoded, accepted);
        check("rand traffic present", accepted > 10, 1'b1);
        check("rand count end", count_b, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bits/s.
REQ-003 SHALL have parameter N_BITS, default 8, data bits per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, input FIFO entries; power of 2, at least 2.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port uart_tx_tdata, input, N_BITS, word to transmit.
REQ-008 SHALL have port uart_tx_tvalid, input, 1, uart_tx_tdata is valid.
REQ-009 SHALL have port uart_tx_tready, output, 1, block can accept a word.
REQ-010 SHALL have port tx_data, output, 1, serial line, registered, idles high.
REQ-011 SHALL have port tx_busy, output, 1, frame in progress or FIFO non-empty.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-013 SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division; 217 at defaults); elaboration SHALL fail if CLKS_PER_BIT < 2.
REQ-014 SHALL accept a word on every rising edge where uart_tx_tvalid && uart_tx_tready, writing it into the FIFO tail.
REQ-015 SHALL drive uart_tx_tready = !full && !rst (combinational from registered state), so a write into a full FIFO is impossible.
REQ-016 SHALL, on a simultaneous FIFO write and FIFO pop in one cycle, leave fifo_count unchanged and preserve word order.
REQ-017 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-018 SHALL implement an FSM with states IDLE, START, DATA, STOP.
REQ-019 SHALL, in IDLE with the FIFO non-empty, pop the head word into the shift register and enter START; tx_data goes low on that same edge.
REQ-020 SHALL hold each state's bit for exactly CLKS_PER_BIT cycles, timed by a baud counter that resets to 0 on every state/bit transition.
REQ-021 SHALL, in START, drive tx_data = 0, then enter DATA.
REQ-022 SHALL, in DATA, drive shift-register bits LSB first, N_BITS bits, then enter STOP.
REQ-023 SHALL, in STOP, drive tx_data = 1 for one bit period; no parity.
REQ-024 SHALL, at the end of STOP, pop the next word and enter START directly if the FIFO is non-empty (contiguous frames of exactly (N_BITS+2)*CLKS_PER_BIT cycles); otherwise enter IDLE.
REQ-025 SHALL give a latency of 1 cycle when idle with an empty FIFO: a word accepted at edge k makes tx_data low from edge k+1.
REQ-026 SHALL drive tx_busy = (state != IDLE) || (fifo_count != 0).
REQ-027 SHALL NOT alter an in-flight frame due to any input activity.

Reset
REQ-028 SHALL, while rst is high at a rising edge, force state IDLE, tx_data = 1, baud counter and bit index = 0, FIFO flushed (fifo_count = 0), tx_busy = 0.
REQ-029 SHALL drive uart_tx_tready = 0 while rst is high and 1 on the first cycle after rst deasserts.
REQ-030 SHALL, on reset asserted mid-frame, abort the frame with tx_data high from the next edge; the aborted word and all queued words are discarded.

Verification
REQ-031 SHALL verify single word: defaults, idle, push 0x55 at edge k -> tx_data low k+1..k+217, then bits 1,0,1,0,1,0,1,0 at 217 cycles each, then high 217 cycles; tx_busy falls at end of stop.
REQ-032 SHALL verify back-to-back: push 0x00,0xFF,0xA5,0x3C,0x81 with tvalid held -> tready low after 4 words are queued (first already popped; count reaches 4), 5 contiguous frames of 2170 cycles each with no idle gap, decoded in order.
REQ-033 SHALL verify simultaneous push/pop: fifo_count = 1 with a frame ending in STOP; push on the popping edge -> fifo_count stays 1 and no word is lost.
REQ-034 SHALL verify reset mid-frame: assert rst for 1 cycle during DATA bit 3 with 2 words queued -> tx_data = 1 and fifo_count = 0 next edge, tready = 1 after release, no further frames.
REQ-035 SHALL verify parameters: CLK_FREQ = 1_000_000, BAUD_RATE = 250_000, N_BITS = 7, push 0x41 -> 4-cycle bits, 9-bit frame of 36 cycles, LSB first.
